// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and constants for the glitch pulse generator
//
// Holds the FSM state encoding, the default parameter widths and the
// trigger filter length used when GLITCH_TRIG_FILTER_EN is defined.

package glitch_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DELAY_W     = 32;
  localparam int DEF_WIDTH_W     = 16;

  // Consecutive high synchronised samples needed before a filtered edge counts.
  localparam int TRIG_FILT_LEN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/glitch_trig_sync.sv
// rtl/glitch_trig_sync.sv - trigger synchroniser, optional filter and rising-edge detector
//
// Ports:
//   clk         - sysclk
//   rst_n       - active-low reset (already synchronised on deassertion)
//   i_trig      - asynchronous external trigger
//   o_trig_edge - one-cycle strobe on a (filtered) synchronised rising edge
//
// Optional feature: GLITCH_TRIG_FILTER_EN adds a TRIG_FILT_LEN-sample
// all-high filter after the synchroniser, delaying the edge by 3 cycles.

module glitch_trig_sync
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trig,
  output logic o_trig_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   level_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig};
    end
  end

`ifdef GLITCH_TRIG_FILTER_EN
  // History of the previous synchronised samples; together with the current
  // sample this gives TRIG_FILT_LEN consecutive samples that must all be high.
  logic [TRIG_FILT_LEN-2:0] filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else begin
      filt_q <= {filt_q[TRIG_FILT_LEN-3:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign level = sync_q[SYNC_STAGES-1] & (&filt_q);
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign o_trig_edge = level & ~level_prev_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// rtl/glitch_pulse_gen.sv - triggered burst glitch pulse generator
//
// Ports:
//   clk, reset_n            - sysclk, asynchronous active-low reset
//   i_arm, i_disarm         - one-cycle arm / abort strobes
//   i_trig                  - asynchronous external trigger
//   i_delay                 - cycles from trigger to first pulse
//   i_width, i_gap          - pulse high / low time in cycles (0 acts as 1)
//   i_count                 - pulses per trigger (0 acts as 1)
//   o_glitch                - glitch pulse, straight from a flop
//   o_armed/o_waiting/o_firing - ARMED / DELAY-or-GAP / PULSE status
//   o_done                  - one-cycle strobe on burst completion or abort
//
// Optional feature: GLITCH_TRIG_FILTER_EN (see glitch_trig_sync).

module glitch_pulse_gen
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DELAY_W     = DEF_DELAY_W,
  parameter int WIDTH_W     = DEF_WIDTH_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_arm,
  input  logic               i_disarm,
  input  logic               i_trig,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [WIDTH_W-1:0] i_width,
  input  logic [WIDTH_W-1:0] i_gap,
  input  logic [7:0]         i_count,
  output logic               o_glitch,
  output logic               o_armed,
  output logic               o_waiting,
  output logic               o_firing,
  output logic               o_done
);

  // Reset asserts asynchronously and releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  logic trig_edge;

  glitch_trig_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk         (clk),
    .rst_n       (rst_n_int),
    .i_trig      (i_trig),
    .o_trig_edge (trig_edge)
  );

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_sh_q, delay_sh_d;
  logic [WIDTH_W-1:0] width_sh_q, width_sh_d;
  logic [WIDTH_W-1:0] gap_sh_q, gap_sh_d;
  logic [7:0]         count_sh_q, count_sh_d;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [WIDTH_W-1:0] tm_cnt_q, tm_cnt_d;
  logic [7:0]         left_q, left_d;
  logic               done_d;
  logic               glitch_q, armed_q, waiting_q, firing_q, done_q;

  // Counters run down to 0, so a phase of N cycles loads N-1; 0 and 1 both load 0.
  logic [WIDTH_W-1:0] width_term, gap_term;
  logic [7:0]         count_term;

  assign width_term = (width_sh_q == '0) ? '0 : width_sh_q - WIDTH_W'(1);
  assign gap_term   = (gap_sh_q   == '0) ? '0 : gap_sh_q   - WIDTH_W'(1);
  assign count_term = (count_sh_q == '0) ? '0 : count_sh_q - 8'd1;

  always_comb begin
    state_d    = state_q;
    delay_sh_d = delay_sh_q;
    width_sh_d = width_sh_q;
    gap_sh_d   = gap_sh_q;
    count_sh_d = count_sh_q;
    dly_cnt_d  = dly_cnt_q;
    tm_cnt_d   = tm_cnt_q;
    left_d     = left_q;
    done_d     = 1'b0;

    // Abort takes priority over any trigger or counter expiry this cycle.
    if (state_q != ST_IDLE && i_disarm) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_arm) begin
            delay_sh_d = i_delay;
            width_sh_d = i_width;
            gap_sh_d   = i_gap;
            count_sh_d = i_count;
            state_d    = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_edge) begin
            state_d   = ST_DELAY;
            dly_cnt_d = delay_sh_q;
            left_d    = count_term;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_q == '0) begin
            state_d  = ST_PULSE;
            tm_cnt_d = width_term;
          end else begin
            dly_cnt_d = dly_cnt_q - DELAY_W'(1);
          end
        end
        ST_PULSE: begin
          if (tm_cnt_q == '0) begin
            if (left_q == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_GAP;
              left_d   = left_q - 8'd1;
              tm_cnt_d = gap_term;
            end
          end else begin
            tm_cnt_d = tm_cnt_q - WIDTH_W'(1);
          end
        end
        ST_GAP: begin
          if (tm_cnt_q == '0) begin
            state_d  = ST_PULSE;
            tm_cnt_d = width_term;
          end else begin
            tm_cnt_d = tm_cnt_q - WIDTH_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state and come straight out of flops.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      delay_sh_q <= '0;
      width_sh_q <= '0;
      gap_sh_q   <= '0;
      count_sh_q <= '0;
      dly_cnt_q  <= '0;
      tm_cnt_q   <= '0;
      left_q     <= '0;
      glitch_q   <= 1'b0;
      armed_q    <= 1'b0;
      waiting_q  <= 1'b0;
      firing_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay_sh_q <= delay_sh_d;
      width_sh_q <= width_sh_d;
      gap_sh_q   <= gap_sh_d;
      count_sh_q <= count_sh_d;
      dly_cnt_q  <= dly_cnt_d;
      tm_cnt_q   <= tm_cnt_d;
      left_q     <= left_d;
      glitch_q   <= (state_d == ST_PULSE);
      armed_q    <= (state_d == ST_ARMED);
      waiting_q  <= (state_d == ST_DELAY) || (state_d == ST_GAP);
      firing_q   <= (state_d == ST_PULSE);
      done_q     <= done_d;
    end
  end

  assign o_glitch  = glitch_q;
  assign o_armed   = armed_q;
  assign o_waiting = waiting_q;
  assign o_firing  = firing_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb/tb_glitch_pulse_gen.sv - self-checking bench for glitch_pulse_gen

module tb_glitch_pulse_gen;

  localparam int SYNC_STAGES = 2;
  localparam int DELAY_W     = 32;
  localparam int WIDTH_W     = 16;
`ifdef GLITCH_TRIG_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               i_arm = 1'b0;
  logic               i_disarm = 1'b0;
  logic               i_trig = 1'b0;
  logic [DELAY_W-1:0] i_delay = '0;
  logic [WIDTH_W-1:0] i_width = '0;
  logic [WIDTH_W-1:0] i_gap = '0;
  logic [7:0]         i_count = '0;
  logic               o_glitch, o_armed, o_waiting, o_firing, o_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glitch_pulse_gen #(
    .SYNC_STAGES (SYNC_STAGES),
    .DELAY_W     (DELAY_W),
    .WIDTH_W     (WIDTH_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_arm     (i_arm),
    .i_disarm  (i_disarm),
    .i_trig    (i_trig),
    .i_delay   (i_delay),
    .i_width   (i_width),
    .i_gap     (i_gap),
    .i_count   (i_count),
    .o_glitch  (o_glitch),
    .o_armed   (o_armed),
    .o_waiting (o_waiting),
    .o_firing  (o_firing),
    .o_done    (o_done)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A burst is described by the edge a at which the trigger is accepted; every
  // later output follows from offset arithmetic on (delay, width, gap, count).
  typedef enum int {M_IDLE, M_ARMED, M_BURST} mmode_t;

  mmode_t    m_mode = M_IDLE;
  int        edge_n = 0;
  int        m_a = 0, m_d = 0, m_w = 1, m_g = 1, m_n = 1;
  bit [15:0] r_hist = '0;
  int        hold = 0;
  bit        e_glitch = 0, e_armed = 0, e_waiting = 0, e_done = 0;

  // Trigger level seen k edges ago (after filtering when enabled).
  function automatic bit f_at(input bit [15:0] h, input int k);
`ifdef GLITCH_TRIG_FILTER_EN
    return h[k] & h[k+1] & h[k+2] & h[k+3];
`else
    return h[k];
`endif
  endfunction

  initial begin : model
    int off, p, per;
    bit acted;
    forever begin
      @(posedge clk);
      edge_n++;
      e_done = 0;
      if (!reset_n) begin
        m_mode = M_IDLE;
        r_hist = '0;
        hold   = 2;
      end else if (hold > 0) begin
        hold--;
        r_hist = '0;
      end else begin
        r_hist = {r_hist[14:0], i_trig};
        acted  = f_at(r_hist, SYNC_STAGES) && !f_at(r_hist, SYNC_STAGES + 1);
        if (m_mode != M_IDLE && i_disarm) begin
          m_mode = M_IDLE;
          e_done = 1;
        end else begin
          case (m_mode)
            M_IDLE: if (i_arm) begin
              m_d    = int'(i_delay);
              m_w    = (i_width == 0) ? 1 : int'(i_width);
              m_g    = (i_gap == 0) ? 1 : int'(i_gap);
              m_n    = (i_count == 0) ? 1 : int'(i_count);
              m_mode = M_ARMED;
            end
            M_ARMED: if (acted) begin
              m_mode = M_BURST;
              m_a    = edge_n;
            end
            default: if (edge_n - m_a == 1 + m_d + m_n * m_w + (m_n - 1) * m_g) begin
              m_mode = M_IDLE;
              e_done = 1;
            end
          endcase
        end
      end
      e_armed   = (m_mode == M_ARMED);
      e_glitch  = 0;
      e_waiting = 0;
      if (m_mode == M_BURST) begin
        off = edge_n - m_a;
        if (off < 1 + m_d) begin
          e_waiting = 1;
        end else begin
          p   = off - 1 - m_d;
          per = m_w + m_g;
          if ((p % per) < m_w) e_glitch = 1;
          else e_waiting = 1;
        end
      end
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("cyc_glitch",  int'(o_glitch),  int'(e_glitch));
        chk("cyc_armed",   int'(o_armed),   int'(e_armed));
        chk("cyc_waiting", int'(o_waiting), int'(e_waiting));
        chk("cyc_firing",  int'(o_firing),  int'(e_glitch));
        chk("cyc_done",    int'(o_done),    int'(e_done));
      end
    end
  end

  // ---------------- directed helpers ----------------
  int rises[$];
  int falls[$];
  int done_off;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input int d, input int w, input int g, input int c);
    @(negedge clk);
    i_delay = 32'(d);
    i_width = 16'(w);
    i_gap   = 16'(g);
    i_count = 8'(c);
    i_arm   = 1'b1;
    @(negedge clk);
    i_arm   = 1'b0;
  endtask

  // Raises i_trig so it is first sampled at edge t0 and records glitch
  // rise/fall and done edges as offsets from t0.
  task automatic trig_and_measure(input int hi, input int budget);
    int  t0;
    bit  prev;
    rises.delete();
    falls.delete();
    done_off = -1;
    @(negedge clk);
    i_trig = 1'b1;
    t0     = edge_n + 1;
    prev   = o_glitch;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i + 1 == hi) i_trig = 1'b0;
      if (o_glitch && !prev) rises.push_back(edge_n - t0);
      if (!o_glitch && prev) falls.push_back(edge_n - t0);
      if (o_done && done_off < 0) done_off = edge_n - t0;
      prev = o_glitch;
    end
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit seen;
    int trig_run;

    @(negedge clk);
    chk("rst_glitch", int'(o_glitch), 0);
    chk("rst_armed",  int'(o_armed),  0);
    chk("rst_done",   int'(o_done),   0);
    tick(2);
    reset_n = 1'b1;
    tick(5);

    // delay=10 width=5 count=1: high edges 13..17, done at 18
    arm(10, 5, 0, 1);
    tick(2);
    trig_and_measure(6, 25 + F);
    chk("t1_npulse", rises.size(), 1);
    chk("t1_rise",   qget(rises, 0), 13 + F);
    chk("t1_fall",   qget(falls, 0), 18 + F);
    chk("t1_done",   done_off, 18 + F);
    tick(3);

    // all zero, count 3: 1-cycle pulses with 1-cycle gaps from edge 3
    arm(0, 0, 0, 3);
    tick(2);
    trig_and_measure(6, 15 + F);
    chk("t2_npulse", rises.size(), 3);
    chk("t2_rise0",  qget(rises, 0), 3 + F);
    chk("t2_rise1",  qget(rises, 1), 5 + F);
    chk("t2_rise2",  qget(rises, 2), 7 + F);
    chk("t2_fall2",  qget(falls, 2), 8 + F);
    chk("t2_done",   done_off, 8 + F);
    tick(3);

    // trigger already high at arm: no fire until a fresh edge
    @(negedge clk);
    i_trig = 1'b1;
    tick(6);
    arm(5, 3, 0, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_glitch) seen = 1;
    end
    chk("t3_armed",    int'(o_armed), 1);
    chk("t3_noglitch", int'(seen), 0);
    @(negedge clk);
    i_trig = 1'b0;
    tick(4);
    trig_and_measure(6, 20 + F);
    chk("t3_rise", qget(rises, 0), 8 + F);
    chk("t3_fall", qget(falls, 0), 11 + F);
    tick(3);

    // abort mid-pulse, later trigger ignored
    arm(2, 100, 0, 1);
    tick(2);
    trig_and_measure(6, 8 + F);
    chk("t4_rise", qget(rises, 0), 5 + F);
    @(negedge clk);
    i_disarm = 1'b1;
    @(negedge clk);
    i_disarm = 1'b0;
    chk("t4_glitch", int'(o_glitch), 0);
    chk("t4_done",   int'(o_done),   1);
    chk("t4_firing", int'(o_firing), 0);
    @(negedge clk);
    chk("t4_done_off", int'(o_done), 0);
    tick(3);
    trig_and_measure(6, 40);
    chk("t4_ignored", rises.size(), 0);
    chk("t4_nodone",  done_off, -1);

    // inputs changed while armed are ignored
    arm(3, 5, 0, 1);
    tick(2);
    @(negedge clk);
    i_width = 16'd50;
    i_delay = 32'd0;
    i_count = 8'd7;
    tick(2);
    trig_and_measure(6, 30 + F);
    chk("t5_rise",  qget(rises, 0), 6 + F);
    chk("t5_width", qget(falls, 0) - qget(rises, 0), 5);
    chk("t5_done",  done_off, 11 + F);
    tick(3);

    // asynchronous reset mid-pulse
    arm(0, 200, 0, 1);
    tick(2);
    trig_and_measure(6, 8 + F);
    chk("t6_rise", qget(rises, 0), 3 + F);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_glitch", int'(o_glitch),  0);
    chk("t6_async_firing", int'(o_firing),  0);
    chk("t6_async_wait",   int'(o_waiting), 0);
    tick(3);
    reset_n = 1'b1;
    tick(4);
    chk("t6_post_glitch", int'(o_glitch), 0);
    chk("t6_post_armed",  int'(o_armed),  0);
    chk("t6_post_done",   int'(o_done),   0);
    arm(1, 1, 1, 1);
    chk("t6_rearm", int'(o_armed), 1);
    tick(5);

    // randomized traffic against the model
    trig_run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) reset_n = 1'b0;
      if (cyc == 1503) reset_n = 1'b1;
      i_arm    = ($urandom_range(0, 11) == 0);
      i_disarm = ($urandom_range(0, 89) == 0);
      if ($urandom_range(0, 3) == 0) begin
        i_delay = 32'($urandom_range(0, 15));
        i_width = 16'($urandom_range(0, 6));
        i_gap   = 16'($urandom_range(0, 6));
        i_count = 8'($urandom_range(0, 4));
      end
      if (trig_run == 0) begin
        i_trig   = ~i_trig;
        trig_run = int'($urandom_range(1, 9));
      end else begin
        trig_run--;
      end
    end
    @(negedge clk);
    i_arm    = 1'b0;
    i_disarm = 1'b0;
    i_trig   = 1'b0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
